// File: rtl/csr_pkg.sv
// csr_pkg: constants shared by the CSR issue scheduler.
//   DEP_NONE     - dependency tag meaning "no producer in flight"
//   *_MSB/*_LSB  - bit positions of the fields inside a queued instruction
//   sched_state_t - sequencing states of csr_issue_sched
package csr_pkg;

  localparam logic [3:0] DEP_NONE = 4'hF;

  localparam int DEP_MSB = 110;
  localparam int DEP_LSB = 107;
  localparam int RS1_MSB = 28;
  localparam int RS1_LSB = 24;
  localparam int CSR_MSB = 43;
  localparam int CSR_LSB = 32;
  localparam int USE_IMM_BIT = 8;
  localparam int IMM_MSB = 75;
  localparam int IMM_LSB = 44;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_OPND = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_WB   = 3'd4
  } sched_state_t;

endpackage

// File: rtl/csr_sched_fifo.sv
// csr_sched_fifo: instruction queue for the CSR scheduler.
//   clk, rstn    - clock / async active-low reset
//   push, push_data - write request; ignored while full
//   pop          - release the head entry; ignored while empty
//   head         - oldest entry (valid when !empty)
//   full, empty, count - occupancy
module csr_sched_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 113
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/csr_issue_sched.sv
// csr_issue_sched: queues CSR instructions and issues them one at a time,
// gathering the left operand (GRF/bypass) and the CSR read value first.
//   clk, rstn                 - clock / async active-low reset
//   enq_*                     - instruction enqueue from issue
//   opreq_*                   - operand read request (rs1, dep tag, csr addr)
//   opl_valid/opl_data        - left operand return
//   csr_rvalid/csr_rdata      - CSR read return
//   exe_valid/ready/data      - {inst, opL, opR} to execute
//   wb_done                   - retirement pulse of the issued op
//   q_empty, q_count          - queue occupancy
//
// state        | meaning
// ST_IDLE      | waiting for a queued op; head latched on leaving
// ST_REQ       | operand request presented
// ST_WAIT_OPND | collecting left operand and CSR value (any order)
// ST_ISSUE     | exe_data presented; pop on exe_ready
// ST_WAIT_WB   | op in flight downstream; next op held until wb_done
module csr_issue_sched #(
  parameter int         DEPTH    = 16,
  parameter int         INST_W   = 113,
  parameter logic [3:0] DEP_NONE = 4'hF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [INST_W-1:0]        enq_inst,
  output logic                     opreq_valid,
  input  logic                     opreq_ready,
  output logic                     opreq_use_byp,
  output logic [4:0]               opreq_rs1,
  output logic [3:0]               opreq_dep,
  output logic [11:0]              opreq_csr,
  input  logic                     opl_valid,
  input  logic [31:0]              opl_data,
  input  logic                     csr_rvalid,
  input  logic [31:0]              csr_rdata,
  output logic                     exe_valid,
  input  logic                     exe_ready,
  output logic [INST_W+63:0]       exe_data,
  input  logic                     wb_done,
  output logic                     q_empty,
  output logic [$clog2(DEPTH):0]   q_count
);

  import csr_pkg::*;

  sched_state_t        state;
  logic [INST_W-1:0]   inst_q;
  logic [INST_W-1:0]   fifo_head;
  logic                fifo_full;
  logic                fifo_pop;
  logic                opl_flag;
  logic                csr_flag;
  logic [31:0]         opl_q;
  logic [31:0]         csr_q;
  logic [INST_W+63:0]  exe_data_q;

  logic                opl_have;
  logic                csr_have;
  logic [31:0]         opl_cur;
  logic [31:0]         csr_cur;
  logic [31:0]         opl_sel;

  assign fifo_pop = (state == ST_ISSUE) && exe_ready;

  csr_sched_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (enq_valid),
    .push_data (enq_inst),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign enq_ready     = !fifo_full;
  assign opreq_valid   = (state == ST_REQ);
  assign opreq_rs1     = inst_q[RS1_MSB:RS1_LSB];
  assign opreq_dep     = inst_q[DEP_MSB:DEP_LSB];
  assign opreq_csr     = inst_q[CSR_MSB:CSR_LSB];
  assign opreq_use_byp = (state == ST_REQ) && (inst_q[DEP_MSB:DEP_LSB] != DEP_NONE);
  assign exe_valid     = (state == ST_ISSUE);
  assign exe_data      = exe_data_q;

  // An operand arriving in the same cycle as the other's flag completes the
  // pair, so the incoming value is forwarded straight into exe_data.
  assign opl_have = opl_flag || opl_valid;
  assign csr_have = csr_flag || csr_rvalid;
  assign opl_cur  = opl_flag ? opl_q : opl_data;
  assign csr_cur  = csr_flag ? csr_q : csr_rdata;
  assign opl_sel  = inst_q[USE_IMM_BIT] ? inst_q[IMM_MSB:IMM_LSB] : opl_cur;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      inst_q     <= '0;
      opl_flag   <= 1'b0;
      csr_flag   <= 1'b0;
      opl_q      <= '0;
      csr_q      <= '0;
      exe_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            inst_q <= fifo_head;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (opreq_ready) state <= ST_WAIT_OPND;
        end
        ST_WAIT_OPND: begin
          if (opl_valid && !opl_flag) begin
            opl_flag <= 1'b1;
            opl_q    <= opl_data;
          end
          if (csr_rvalid && !csr_flag) begin
            csr_flag <= 1'b1;
            csr_q    <= csr_rdata;
          end
          if (opl_have && csr_have) begin
            exe_data_q <= {inst_q, opl_sel, csr_cur};
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (exe_ready) begin
            opl_flag <= 1'b0;
            csr_flag <= 1'b0;
            state    <= ST_WAIT_WB;
          end
        end
        ST_WAIT_WB: begin
          if (wb_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
